// File: rtl/sound_sample_dma.sv
// Fetches 32-bit sample words from memory and streams them, little-endian byte by byte,
// into the sound core buffer, with optional looping and a per-pass done interrupt.
module sound_sample_dma #(
  parameter int BUFFER_DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] startAddrIn,
  input  logic [15:0] lengthIn,
  input  logic        loopEnIn,
  input  logic        doneIreIn,
  input  logic        configLoadEn,
  input  logic        startEn,
  input  logic        stopEn,
  output logic        memReadReq,
  output logic [31:0] memAddress,
  input  logic        memReadAck,
  input  logic [31:0] memReadData,
  input  logic [9:0]  wordCount,
  output logic [7:0]  bufferDataOut,
  output logic        bufferLoadEn,
  output logic        busy,
  output logic [15:0] wordsRemaining,
  output logic        doneIrq
);

  localparam int          DATA_W     = 32;
  localparam logic [31:0] FILL_LIMIT = 32'(BUFFER_DEPTH - 4);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    UNPACK,
    DRAIN
  } state_t;

  state_t state, nextState;

  logic [31:2]       cfgAddr;
  logic [15:0]       cfgLength;
  logic              cfgLoopEn;
  logic              cfgDoneIre;

  logic [31:2]       curAddr;
  logic [15:0]       remaining;
  logic [1:0]        byteIdx;
  logic [DATA_W-1:0] wordData_p1;

  logic              loadBlock;
  logic              reloadBlock;
  logic              captureWord;
  logic              passDone;
  logic              roomForWord;

  // Byte lanes are word-aligned by construction, so the low address bits are dropped.
  logic              unusedAddrBits;
  assign unusedAddrBits = ^startAddrIn[1:0];

  function automatic logic [7:0] selectByte(input logic [DATA_W-1:0] word,
                                            input logic [1:0]        idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  assign roomForWord = ({22'd0, wordCount} <= FILL_LIMIT);

  always_comb begin
    nextState   = state;
    loadBlock   = 1'b0;
    reloadBlock = 1'b0;
    captureWord = 1'b0;
    passDone    = 1'b0;
    case (state)
      IDLE: begin
        if (!stopEn && startEn && (cfgLength != 16'd0)) begin
          loadBlock = 1'b1;
          nextState = CHECK;
        end
      end
      CHECK: begin
        if (stopEn)
          nextState = IDLE;
        else if (roomForWord)
          nextState = REQ;
      end
      REQ: begin
        // A stop that coincides with the ack simply drops the returned word.
        if (memReadAck) begin
          if (stopEn) begin
            nextState = IDLE;
          end else begin
            captureWord = 1'b1;
            nextState   = UNPACK;
          end
        end else if (stopEn) begin
          nextState = DRAIN;
        end
      end
      UNPACK: begin
        if (stopEn) begin
          nextState = IDLE;
        end else if (byteIdx == 2'd3) begin
          if (remaining != 16'd0) begin
            nextState = CHECK;
          end else begin
            passDone = 1'b1;
            // A loop reload with a zero-length config would never fetch, so stop instead.
            if (cfgLoopEn && (cfgLength != 16'd0)) begin
              reloadBlock = 1'b1;
              nextState   = CHECK;
            end else begin
              nextState = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        if (memReadAck)
          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfgAddr    <= '0;
      cfgLength  <= '0;
      cfgLoopEn  <= 1'b0;
      cfgDoneIre <= 1'b0;
    end else if (configLoadEn) begin
      cfgAddr    <= startAddrIn[31:2];
      cfgLength  <= lengthIn;
      cfgLoopEn  <= loopEnIn;
      cfgDoneIre <= doneIreIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curAddr   <= '0;
      remaining <= '0;
      byteIdx   <= '0;
      doneIrq   <= 1'b0;
    end else begin
      if (loadBlock || reloadBlock) begin
        curAddr   <= cfgAddr;
        remaining <= cfgLength;
      end else if (captureWord) begin
        curAddr   <= curAddr + 30'd1;
        remaining <= remaining - 16'd1;
      end
      if (captureWord)
        byteIdx <= 2'd0;
      else if (state == UNPACK)
        byteIdx <= byteIdx + 2'd1;
      doneIrq <= passDone && cfgDoneIre;
    end
  end

  // Stage p1: fetched word held while its four bytes are unpacked
  always_ff @(posedge clk) begin
    if (captureWord)
      wordData_p1 <= memReadData;
  end

  assign memReadReq     = (state == REQ) || (state == DRAIN);
  assign memAddress     = {curAddr, 2'b00};
  assign bufferLoadEn   = (state == UNPACK);
  assign bufferDataOut  = bufferLoadEn ? selectByte(wordData_p1, byteIdx) : 8'd0;
  assign busy           = (state != IDLE);
  assign wordsRemaining = remaining;

endmodule

// File: tb/tb_sound_sample_dma.sv
// Scoreboard bench for sound_sample_dma: stimulus queues expected addresses and bytes,
// a monitor checks them as the DUT presents requests and buffer writes.
module tb_sound_sample_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] startAddrIn;
  logic [15:0] lengthIn;
  logic        loopEnIn;
  logic        doneIreIn;
  logic        configLoadEn;
  logic        startEn;
  logic        stopEn;
  logic        memReadReq;
  logic [31:0] memAddress;
  logic        memReadAck;
  logic [31:0] memReadData;
  logic [9:0]  wordCount;
  logic [7:0]  bufferDataOut;
  logic        bufferLoadEn;
  logic        busy;
  logic [15:0] wordsRemaining;
  logic        doneIrq;

  always #5 clk = ~clk;

  sound_sample_dma #(.BUFFER_DEPTH(512)) dut (
    .clk(clk), .reset(reset),
    .startAddrIn(startAddrIn), .lengthIn(lengthIn), .loopEnIn(loopEnIn),
    .doneIreIn(doneIreIn), .configLoadEn(configLoadEn),
    .startEn(startEn), .stopEn(stopEn),
    .memReadReq(memReadReq), .memAddress(memAddress),
    .memReadAck(memReadAck), .memReadData(memReadData),
    .wordCount(wordCount),
    .bufferDataOut(bufferDataOut), .bufferLoadEn(bufferLoadEn),
    .busy(busy), .wordsRemaining(wordsRemaining), .doneIrq(doneIrq)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int ackDelay = 1;
  int ackCyc = -100;
  int reqRises = 0;
  int bytesSeen = 0;
  int irqCount = 0;
  int lastReqLen = 0;

  logic [31:0] expAddr[$];
  logic [7:0]  expByte[$];
  logic [31:0] memData[logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got 0x%0h, none expected", name, act);
  endtask

  // Memory responder: ack ackDelay cycles after the request is first seen
  initial begin
    int cnt;
    cnt = 0;
    memReadAck = 1'b0;
    memReadData = 32'd0;
    forever begin
      @(negedge clk);
      if (memReadAck) begin
        memReadAck = 1'b0;
        cnt = 0;
      end else if (memReadReq && !reset) begin
        if (cnt == ackDelay) begin
          memReadAck = 1'b1;
          memReadData = memData.exists(memAddress) ? memData[memAddress] : 32'hDEADBEEF;
          ackCyc = cyc;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    logic        prevReq;
    logic [31:0] heldAddr;
    int          irqRun;
    prevReq = 1'b0;
    heldAddr = 32'd0;
    irqRun = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevReq = 1'b0;
        irqRun = 0;
      end else begin
        if (memReadReq && !prevReq) begin
          reqRises++;
          lastReqLen = 1;
          if (expAddr.size() == 0) unexpected("unexpected_req", memAddress);
          else check("req_addr", memAddress, expAddr.pop_front());
          check("addr_aligned", {30'd0, memAddress[1:0]}, 32'd0);
          heldAddr = memAddress;
        end else if (memReadReq) begin
          lastReqLen++;
          check("addr_stable", memAddress, heldAddr);
        end
        prevReq = memReadReq;
        if (bufferLoadEn) begin
          bytesSeen++;
          check("byte_after_ack", {31'd0, (cyc - ackCyc >= 1) && (cyc - ackCyc <= 4)}, 32'd1);
          if (expByte.size() == 0) unexpected("unexpected_byte", {24'd0, bufferDataOut});
          else check("byte", {24'd0, bufferDataOut}, {24'd0, expByte.pop_front()});
        end
        if (doneIrq) begin
          irqCount++;
          irqRun++;
        end else begin
          if (irqRun > 0) check("irq_width", irqRun, 1);
          irqRun = 0;
        end
      end
    end
  end

  task automatic loadConfig(input logic [31:0] a, input logic [15:0] l, input logic lp, input logic ire);
    @(negedge clk);
    startAddrIn = a; lengthIn = l; loopEnIn = lp; doneIreIn = ire;
    configLoadEn = 1'b1;
    @(negedge clk);
    configLoadEn = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    startEn = 1'b1;
    @(negedge clk);
    startEn = 1'b0;
  endtask

  task automatic waitReq(input int maxc, output int at);
    int n;
    n = 0;
    while (!memReadReq && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("wait_req_timeout", {31'd0, memReadReq}, 32'd1);
    at = cyc;
  endtask

  task automatic waitIdle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic waitBytes(input int target, input int maxc);
    int n;
    n = 0;
    while (bytesSeen < target && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_bytes_timeout", bytesSeen, target);
  endtask

  task automatic pushWord(input logic [31:0] a, input logic [31:0] d);
    memData[a] = d;
    expAddr.push_back(a);
    expByte.push_back(d[7:0]);
    expByte.push_back(d[15:8]);
    expByte.push_back(d[23:16]);
    expByte.push_back(d[31:24]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, at, irqBase, reqBase, byteBase;
    reset = 1'b1;
    startAddrIn = 32'd0; lengthIn = 16'd0; loopEnIn = 1'b0; doneIreIn = 1'b0;
    configLoadEn = 1'b0; startEn = 1'b0; stopEn = 1'b0; wordCount = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, memReadReq}, 32'd0);
    check("rst_addr", memAddress, 32'd0);
    check("rst_loaden", {31'd0, bufferLoadEn}, 32'd0);
    check("rst_data", {24'd0, bufferDataOut}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_remaining", {16'd0, wordsRemaining}, 32'd0);
    check("rst_irq", {31'd0, doneIrq}, 32'd0);
    reset = 1'b0;

    // Two-word block, unaligned start address, interrupt enabled
    loadConfig(32'h1003, 16'd2, 1'b0, 1'b1);
    pushWord(32'h1000, 32'h44332211);
    pushWord(32'h1004, 32'h88776655);
    irqBase = irqCount;
    @(negedge clk);
    startEn = 1'b1;
    s = cyc;
    @(negedge clk);
    startEn = 1'b0;
    check("t1_remaining_start", {16'd0, wordsRemaining}, 32'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    waitReq(20, at);
    check("t1_req_latency", at - s, 2);
    waitIdle(100);
    repeat (3) @(negedge clk);
    check("t1_irq_count", irqCount - irqBase, 1);
    check("t1_bytes_left", expByte.size(), 0);
    check("t1_addr_left", expAddr.size(), 0);
    check("t1_remaining_end", {16'd0, wordsRemaining}, 32'd0);

    // Buffer fill threshold
    wordCount = 10'd509;
    loadConfig(32'h3000, 16'd1, 1'b0, 1'b0);
    pushWord(32'h3000, 32'hA1B2C3D4);
    reqBase = reqRises;
    irqBase = irqCount;
    pulseStart();
    repeat (10) @(negedge clk);
    check("t2_no_req_full", reqRises - reqBase, 0);
    check("t2_busy_waiting", {31'd0, busy}, 32'd1);
    wordCount = 10'd508;
    s = cyc;
    waitReq(20, at);
    check("t2_req_after_drop", at - s, 1);
    waitIdle(100);
    wordCount = 10'd0;
    repeat (2) @(negedge clk);
    check("t2_irq_none", irqCount - irqBase, 0);
    check("t2_bytes_left", expByte.size(), 0);

    // Looping with reconfiguration during the first pass
    loadConfig(32'h1800, 16'd1, 1'b1, 1'b1);
    pushWord(32'h1800, 32'h04030201);
    pushWord(32'h2000, 32'h08070605);
    irqBase = irqCount;
    byteBase = bytesSeen;
    pulseStart();
    waitBytes(byteBase + 1, 50);
    loadConfig(32'h2000, 16'd1, 1'b1, 1'b1);
    waitBytes(byteBase + 8, 100);
    @(negedge clk);
    stopEn = 1'b1;
    @(negedge clk);
    stopEn = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t3_irq_per_pass", irqCount - irqBase, 2);
    check("t3_bytes_left", expByte.size(), 0);
    check("t3_addr_left", expAddr.size(), 0);

    // Stop while a read is pending
    ackDelay = 5;
    loadConfig(32'h4000, 16'd3, 1'b0, 1'b1);
    expAddr.push_back(32'h4000);
    irqBase = irqCount;
    byteBase = bytesSeen;
    pulseStart();
    waitReq(20, at);
    @(negedge clk);
    stopEn = 1'b1;
    @(negedge clk);
    stopEn = 1'b0;
    waitIdle(50);
    repeat (3) @(negedge clk);
    check("t4_req_held", lastReqLen, 6);
    check("t4_no_bytes", bytesSeen - byteBase, 0);
    check("t4_no_irq", irqCount - irqBase, 0);
    check("t4_addr_left", expAddr.size(), 0);
    ackDelay = 1;

    // Zero length, start while busy, reset mid-unpack
    loadConfig(32'h7000, 16'd0, 1'b0, 1'b1);
    reqBase = reqRises;
    pulseStart();
    repeat (5) @(negedge clk);
    check("t5_len0_busy", {31'd0, busy}, 32'd0);
    check("t5_len0_no_req", reqRises - reqBase, 0);
    loadConfig(32'h5000, 16'd2, 1'b0, 1'b1);
    memData[32'h5000] = 32'hCAFEF00D;
    expAddr.push_back(32'h5000);
    expByte.push_back(8'h0D);
    expByte.push_back(8'hF0);
    reqBase = reqRises;
    irqBase = irqCount;
    byteBase = bytesSeen;
    @(negedge clk);
    startEn = 1'b1;
    @(negedge clk);
    startEn = 1'b0;
    startAddrIn = 32'h6000; lengthIn = 16'd5; configLoadEn = 1'b1;
    @(negedge clk);
    configLoadEn = 1'b0;
    startEn = 1'b1;
    @(negedge clk);
    startEn = 1'b0;
    waitBytes(byteBase + 2, 50);
    reset = 1'b1;
    #1;
    check("t5_rst_req", {31'd0, memReadReq}, 32'd0);
    check("t5_rst_addr", memAddress, 32'd0);
    check("t5_rst_loaden", {31'd0, bufferLoadEn}, 32'd0);
    check("t5_rst_data", {24'd0, bufferDataOut}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_remaining", {16'd0, wordsRemaining}, 32'd0);
    check("t5_rst_irq", {31'd0, doneIrq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_one_req", reqRises - reqBase, 1);
    check("t5_two_bytes", bytesSeen - byteBase, 2);
    check("t5_no_irq", irqCount - irqBase, 0);
    check("t5_busy_end", {31'd0, busy}, 32'd0);
    check("t5_bytes_left", expByte.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sound_sample_dma.md
SOUND_SAMPLE_DMA -- requirements
Module: sound_sample_dma

Interface
REQ-001 BUFFER_DEPTH, default 512, byte capacity of the downstream sound sample buffer.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 startAddrIn  input  32  sample block byte address; bits [1:0] ignored.
REQ-005 lengthIn  input  16  block length in 32-bit words.
REQ-006 loopEnIn  input  1  replay the block continuously when set.
REQ-007 doneIreIn  input  1  done-interrupt enable.
REQ-008 configLoadEn  input  1  latches startAddrIn, lengthIn, loopEnIn and doneIreIn into the config registers.
REQ-009 startEn  input  1  single-cycle start pulse.
REQ-010 stopEn  input  1  single-cycle stop pulse.
REQ-011 memReadReq  output  1  word read request, held until acknowledged.
REQ-012 memAddress  output  32  word-aligned read address, stable while memReadReq is high.
REQ-013 memReadAck  input  1  read complete; memReadData is valid in the same cycle.
REQ-014 memReadData  input  32  read data.
REQ-015 wordCount  input  10  current byte fill level of the downstream buffer.
REQ-016 bufferDataOut  output  8  sample byte to the sound core buffer.
REQ-017 bufferLoadEn  output  1  buffer write strobe, one byte per cycle.
REQ-018 busy  output  1  high whenever the state is not IDLE.
REQ-019 wordsRemaining  output  16  words of the current pass not yet fetched.
REQ-020 doneIrq  output  1  single-cycle pass-complete interrupt.

Function
REQ-021 The FSM SHALL have exactly five states: IDLE, CHECK, REQ, UNPACK and DRAIN.
REQ-022 IDLE: on startEn with config length != 0 the block SHALL load curAddr = {startAddr[31:2], 2'b00} and remaining = length, then enter CHECK; startEn with length 0 SHALL be ignored.
REQ-023 CHECK: when wordCount <= BUFFER_DEPTH-4 the FSM SHALL enter REQ on the next cycle; otherwise it SHALL stay in CHECK.
REQ-024 REQ: memReadReq = 1 and memAddress = curAddr. On memReadAck the block SHALL capture memReadData, advance curAddr by 4 (modulo 2^32), decrement remaining and enter UNPACK.
REQ-025 UNPACK: bufferLoadEn SHALL be high for exactly 4 consecutive cycles, carrying bytes [7:0], [15:8], [23:16] and [31:24] in that order (little-endian).
REQ-026 After the 4th byte, if remaining != 0 the FSM SHALL enter CHECK.
REQ-027 After the 4th byte, if remaining == 0 and loopEn = 1, the block SHALL reload curAddr and remaining from the current config registers and enter CHECK.
REQ-028 After the 4th byte, if remaining == 0 and loopEn = 0, the FSM SHALL enter IDLE.
REQ-029 When the last word of a pass is written (looping or not), doneIrq SHALL be registered high for exactly one cycle if doneIre = 1.
REQ-030 stopEn SHALL take priority over startEn and SHALL act per state: IDLE no effect; CHECK goes to IDLE next cycle; UNPACK goes to IDLE next cycle and the unwritten bytes are discarded; REQ goes to DRAIN.
REQ-031 DRAIN SHALL hold memReadReq and memAddress until memReadAck, discard the data, then enter IDLE.
REQ-032 stopEn SHALL never produce doneIrq.
REQ-033 startEn while busy = 1 SHALL be ignored.
REQ-034 configLoadEn while busy SHALL update only the config registers. The active pass is unaffected; the next loop reload uses the new values.
REQ-035 At most one memory read SHALL be outstanding at any time.
REQ-036 memAddress SHALL be word-aligned at all times.
REQ-037 Latency: with startEn in cycle 0 and the buffer empty, memReadReq SHALL rise in cycle 2; with ack in cycle n, bufferLoadEn SHALL be high in cycles n+1 to n+4.

Reset
REQ-038 On reset: state = IDLE, memReadReq = 0, memAddress = 0, bufferLoadEn = 0, bufferDataOut = 0, busy = 0, wordsRemaining = 0, doneIrq = 0, all config registers = 0.
REQ-039 Reset asserted mid-transfer SHALL abandon any pending read immediately, with no write strobe or irq afterwards.

Verification
REQ-040 Config addr 0x1003, len 2, ire 1, ack 1 cycle after req, data 0x44332211 then 0x88776655 -> addresses 0x1000 then 0x1004; bytes 11 22 33 44 55 66 77 88; one doneIrq; busy falls.
REQ-041 wordCount held at 509, DEPTH 512, then dropped to 508 -> no memReadReq while at 509; request issued 1 cycle after the drop.
REQ-042 len 1, loop 1, with reconfig to addr 0x2000 during the first pass -> second fetch reads 0x2000; doneIrq fires once per pass.
REQ-043 stopEn in REQ with ack delayed 5 cycles -> request held until ack, no bufferLoadEn, IDLE, no doneIrq.
REQ-044 Start with len 0; start pulsed while busy; reset mid-UNPACK -> no reads; no restart; all outputs at reset values immediately.
